comparator: RTL and testbench
=============================

// Module: comparator
// PURPOSE
//   Registered magnitude comparator: compares two WIDTH-bit operands A and B and
//   reports exactly one of GT (A>B), LT (A<B), EQ (A==B). Used as a leaf compare
//   stage in datapath/control logic. Result is registered on clk, with a valid
//   qualifier so it can sit in a pipeline.
// PARAMETERS
//   WIDTH   2   operand width in bits (>=1)
//   SIGNED  0   0: unsigned compare; 1: two's-complement signed compare
// PORTS
//   clk        in   1      system clock, all state updates on rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      A/B are valid this cycle; compare is captured
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   GT         out  1      registered: A > B
//   LT         out  1      registered: A < B
//   EQ         out  1      registered: A == B
//   out_valid  out  1      GT/LT/EQ hold a result captured from a valid input
// BEHAVIOUR
//   - Reset (rst=1 at rising edge): GT=0, LT=0, EQ=0, out_valid=0; rst overrides
//     in_valid in the same cycle; in-flight result discarded.
//   - Latency 1 cycle: in_valid=1 at edge N -> GT/LT/EQ reflect A,B from edge N
//     and out_valid=1 after edge N.
//   - in_valid=0 at an edge: GT/LT/EQ hold previous values; out_valid drops to 0.
//   - No backpressure: a new compare may be issued every cycle (throughput 1).
//   - After first valid capture, exactly one of GT/LT/EQ is 1 (one-hot);
//     before any capture after reset all three are 0.
//   - SIGNED=0: operands unsigned, range 0..2^WIDTH-1.
//   - SIGNED=1: MSB is sign; e.g. WIDTH=2: 2'b10 (-2) < 2'b01 (+1).
//   - Combinational compare path is full-width; no truncation or overflow.
//   - Inputs X/Z are not handled; bench drives only known values.
// TESTING
//   1 reset: rst=1 two cycles -> GT=LT=EQ=0, out_valid=0.
//   2 A=0,B=0,in_valid=1 -> next cycle EQ=1, GT=0, LT=0, out_valid=1.
//   3 A=2,B=1 -> GT=1; then A=1,B=2 -> LT=1; then A=2,B=2 -> EQ=1
//     (back-to-back valid cycles, one result per cycle, 1-cycle latency).
//   4 in_valid=0 with A=3,B=0 after case 3 -> EQ stays 1, out_valid=0.
//   5 SIGNED=1, WIDTH=2: A=2'b10,B=2'b01 -> LT=1; unsigned build same -> GT=1.
//   6 exhaustive WIDTH=2 sweep of all 16 A/B pairs vs model; assert one-hot;
//     assert rst mid-stream clears outputs on the next edge.

Source files
------------

// File: rtl/comparator.sv
// Registered magnitude comparator: one-hot GT/LT/EQ of operands A and B, unsigned or two's-complement.
// Latency 1 cycle from in_valid to out_valid; result holds while in_valid is low.
// No backpressure: accepts a new compare every cycle.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset, overrides in_valid
//   in_valid   A/B valid this cycle; the compare result is captured
//   A, B       WIDTH-bit operands
//   GT/LT/EQ   registered A>B / A<B / A==B, one-hot after the first capture
//   out_valid  high for the cycle after a captured compare
module comparator #(
  parameter int WIDTH  = 2,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             GT,
  output logic             LT,
  output logic             EQ,
  output logic             out_valid
);

  // Inverting the sign bit maps two's-complement order onto unsigned order,
  // so one full-width unsigned compare serves both modes.
  logic [WIDTH-1:0] sign_flip;
  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;
  logic             gt_c;
  logic             lt_c;
  logic             eq_c;

  always_comb begin
    sign_flip            = '0;
    sign_flip[WIDTH-1]   = SIGNED;
    a_key                = A ^ sign_flip;
    b_key                = B ^ sign_flip;
    gt_c                 = (a_key > b_key);
    lt_c                 = (a_key < b_key);
    eq_c                 = (A == B);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      GT        <= 1'b0;
      LT        <= 1'b0;
      EQ        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Flags are only updated on a valid input; otherwise the last result is held.
      if (in_valid) begin
        GT <= gt_c;
        LT <= lt_c;
        EQ <= eq_c;
      end
    end
  end

endmodule

// File: tb/tb_comparator.sv
module tb_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] a;
  logic [1:0] b;

  logic u_gt, u_lt, u_eq, u_ov;
  logic s_gt, s_lt, s_eq, s_ov;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  comparator #(.WIDTH(2), .SIGNED(1'b0)) u_uns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
    .GT(u_gt), .LT(u_lt), .EQ(u_eq), .out_valid(u_ov)
  );

  comparator #(.WIDTH(2), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
    .GT(s_gt), .LT(s_lt), .EQ(s_eq), .out_valid(s_ov)
  );

  // Result vectors are packed as {out_valid, GT, LT, EQ}.
  function automatic logic [3:0] uns_res();
    return {u_ov, u_gt, u_lt, u_eq};
  endfunction

  function automatic logic [3:0] sgn_res();
    return {s_ov, s_gt, s_lt, s_eq};
  endfunction

  // Reference: compare as integers, sign-extending when signed.
  function automatic logic [3:0] model(input int av, input int bv, input bit sgn);
    int x;
    int y;
    x = av;
    y = bv;
    if (sgn) begin
      if (x >= 2) x = x - 4;
      if (y >= 2) y = y - 4;
    end
    return {1'b1, (x > y), (x < y), (x == y)};
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Apply inputs just after an edge, clock once, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic v, input logic [1:0] av, input logic [1:0] bv);
    rst      = r;
    in_valid = v;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 2'd0; b = 2'd0;

    // Reset held two cycles
    step(1'b1, 1'b0, 2'd0, 2'd0);
    step(1'b1, 1'b0, 2'd0, 2'd0);
    check("reset_uns", uns_res(), 4'b0000);
    check("reset_sgn", sgn_res(), 4'b0000);

    // 0 vs 0
    step(1'b0, 1'b1, 2'd0, 2'd0);
    check("eq00_uns", uns_res(), 4'b1001);
    check("eq00_sgn", sgn_res(), 4'b1001);

    // Back-to-back: 2v1, 1v2, 2v2 (2'b10 is -2 when signed)
    step(1'b0, 1'b1, 2'd2, 2'd1);
    check("gt21_uns", uns_res(), 4'b1100);
    check("lt21_sgn", sgn_res(), 4'b1010);
    step(1'b0, 1'b1, 2'd1, 2'd2);
    check("lt12_uns", uns_res(), 4'b1010);
    check("gt12_sgn", sgn_res(), 4'b1100);
    step(1'b0, 1'b1, 2'd2, 2'd2);
    check("eq22_uns", uns_res(), 4'b1001);
    check("eq22_sgn", sgn_res(), 4'b1001);

    // Invalid cycle: flags hold, out_valid drops
    step(1'b0, 1'b0, 2'd3, 2'd0);
    check("hold_uns", uns_res(), 4'b0001);
    check("hold_sgn", sgn_res(), 4'b0001);

    // Exhaustive sweep with one-hot check
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        step(1'b0, 1'b1, 2'(i), 2'(j));
        check($sformatf("sweep_uns_%0d_%0d", i, j), uns_res(), model(i, j, 1'b0));
        check($sformatf("sweep_sgn_%0d_%0d", i, j), sgn_res(), model(i, j, 1'b1));
        check($sformatf("onehot_uns_%0d_%0d", i, j), 4'($countones({u_gt, u_lt, u_eq})), 4'd1);
        check($sformatf("onehot_sgn_%0d_%0d", i, j), 4'($countones({s_gt, s_lt, s_eq})), 4'd1);
      end
    end

    // Mid-stream reset, asserted together with a valid input
    step(1'b0, 1'b1, 2'd3, 2'd1);
    check("pre_rst_uns", uns_res(), 4'b1100);
    check("pre_rst_sgn", sgn_res(), 4'b1010);
    step(1'b1, 1'b1, 2'd0, 2'd0);
    check("midrst_uns", uns_res(), 4'b0000);
    check("midrst_sgn", sgn_res(), 4'b0000);
    step(1'b0, 1'b0, 2'd1, 2'd0);
    check("postrst_idle_uns", uns_res(), 4'b0000);
    check("postrst_idle_sgn", sgn_res(), 4'b0000);
    step(1'b0, 1'b1, 2'd1, 2'd1);
    check("postrst_eq_uns", uns_res(), 4'b1001);
    check("postrst_eq_sgn", sgn_res(), 4'b1001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
